// File: rtl/logic_op_pkg.sv
// -----------------------------------------------------------------------------
// logic_op_pkg
//   Shared definitions for the logic_op_pipe block.
//   - OP_* : 3-bit operation codes accepted on in_op.
//   - logic_op(a, b, op) : one-bit bitwise logic function. The top applies it
//     to every bit lane, so the unit works for any WIDTH without a width-fixed
//     helper.
// -----------------------------------------------------------------------------
package logic_op_pkg;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASA = 3'd6;
  localparam logic [2:0] OP_NOTA = 3'd7;

  // Per-bit logic operation; B is ignored for OP_PASA and OP_NOTA.
  function automatic logic logic_op(input logic a, input logic b, input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASA: r = a;
      OP_NOTA: r = ~a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_fifo.sv
// -----------------------------------------------------------------------------
// logic_op_fifo
//   Generic synchronous FIFO, WIDTH_E bits x DEPTH entries (DEPTH a power of
//   two, >= 2). Pointers wrap naturally from DEPTH-1 to 0.
// Ports
//   clk     in   clock, posedge
//   rst     in   synchronous active-high reset (pointers and count to 0)
//   push    in   write wr_data at tail (ignored when full)
//   pop     in   advance head (ignored when empty)
//   wr_data in   entry to write
//   rd_data out  entry at head, all zeros when empty
//   full    out  count == DEPTH
//   empty   out  count == 0
//   count   out  number of stored entries
// -----------------------------------------------------------------------------
module logic_op_fifo #(
  parameter int WIDTH_E = 10,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH_E-1:0]           wr_data,
  output logic [WIDTH_E-1:0]           rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH_E-1:0] mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observable through rd_data while non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Head read, forced to zero when empty so stale entries never leak out.
  always_comb begin
    rd_data = {WIDTH_E{1'b0}};
    if (empty) begin
      rd_data = {WIDTH_E{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// -----------------------------------------------------------------------------
// logic_op_pipe
//   WIDTH-bit bitwise logic unit with 8 ops (see logic_op_pkg), operand
//   valid/ready input and a DEPTH-entry result FIFO on the output. Each entry
//   holds the result plus its zero/ones flags (and parity when enabled).
//   Optional feature macro: LOGIC_OP_PARITY_EN adds the out_parity port and
//   stores the parity bit in each FIFO entry.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready depends only on rst and
//                       the registered count (no path from out_ready)
//   in_a, in_b, in_op   operands and operation select
//   out_valid/out_ready result handshake; out_valid = FIFO non-empty
//   out_data            head result (0 when empty)
//   out_zero, out_ones  head result is all zeros / all ones
//   out_parity          XOR-reduce of head result (LOGIC_OP_PARITY_EN only)
// -----------------------------------------------------------------------------
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
`ifdef LOGIC_OP_PARITY_EN
  output logic             out_ones,
  output logic             out_parity
`else
  output logic             out_ones
`endif
);

`ifdef LOGIC_OP_PARITY_EN
  localparam int WIDTH_E = WIDTH + 3;
`else
  localparam int WIDTH_E = WIDTH + 2;
`endif
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   res_s;
  logic               zero_s;
  logic               ones_s;
  logic [WIDTH_E-1:0] wr_data_s;
  logic [WIDTH_E-1:0] rd_data_s;
  logic               full_s;
  logic               empty_s;
  logic [CW-1:0]      count_s;
  logic               in_ready_s;
  logic               push_s;
  logic               pop_s;

  // Each result bit only depends on the matching operand bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign res_s[i] = logic_op(in_a[i], in_b[i], in_op);
  end

  assign zero_s = ~|res_s;
  assign ones_s = &res_s;

`ifdef LOGIC_OP_PARITY_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  assign wr_data_s  = {parity_of(res_s), ones_s, zero_s, res_s};
  assign out_parity = rd_data_s[WIDTH+2];
`else
  assign wr_data_s  = {ones_s, zero_s, res_s};
`endif

  // Ready is held low during reset and whenever the FIFO is full, so a pop in
  // the same cycle never opens a pass-through slot.
  assign in_ready_s = ~rst & (count_s != CW'(DEPTH));
  assign in_ready   = in_ready_s;
  assign push_s     = in_valid & in_ready_s & ~full_s;
  assign pop_s      = out_ready & ~empty_s;

  assign out_valid  = ~empty_s;
  assign out_data   = rd_data_s[WIDTH-1:0];
  assign out_zero   = rd_data_s[WIDTH];
  assign out_ones   = rd_data_s[WIDTH+1];

  logic_op_fifo #(
    .WIDTH_E (WIDTH_E),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_data_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

endmodule

// File: tb/tb_logic_op_pipe.sv
module tb_logic_op_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
`ifdef LOGIC_OP_PARITY_EN
  logic             out_parity;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] got_q [$];
  logic             prev_rst = 1'b1;

  logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
`ifdef LOGIC_OP_PARITY_EN
    .out_ones   (out_ones),
    .out_parity (out_parity)
`else
    .out_ones   (out_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
    case (op)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  // Scoreboard: sample handshakes on the falling edge, pop before push
  always @(negedge clk) begin
    if (rst) begin
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      if (prev_rst) check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      exp_q.delete();
    end else begin
      check_val("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < DEPTH)});
      check_val("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
      if (out_valid && out_ready) begin
        check_val("sb_underflow", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          check_val("out_data", {24'd0, out_data}, {24'd0, e});
          check_val("out_zero", {31'd0, out_zero}, {31'd0, (e == 8'h00)});
          check_val("out_ones", {31'd0, out_ones}, {31'd0, (e == 8'hFF)});
`ifdef LOGIC_OP_PARITY_EN
          check_val("out_parity", {31'd0, out_parity}, {31'd0, ^e});
`endif
          got_q.push_back(out_data);
        end
      end else if (!out_valid) begin
        check_val("idle_data", {24'd0, out_data}, 32'd0);
        check_val("idle_flags", {30'd0, out_zero, out_ones}, 32'd0);
      end
      if (in_valid && in_ready) exp_q.push_back(model_op(in_a, in_b, in_op));
    end
    prev_rst = rst;
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                      output int waits);
    logic ok;
    ok = 1'b0;
    waits = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    check_val("send_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_val("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [WIDTH-1:0] t2_exp [8];
    logic [WIDTH-1:0] new_a [2];
    t2_exp = '{8'hFC, 8'h30, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'hF0, 8'h0F};
    new_a  = '{8'h5A, 8'hC3};

    // 1: reset with in_valid high, nothing may be accepted
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 8'h12;
    in_b = 8'h34;
    in_op = 3'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("t1_ready_after_rst", {31'd0, in_ready}, 32'd1);
    check_val("t1_no_push", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 2: all eight ops on F0/3C
    got_q.delete();
    for (int op = 0; op < 8; op++) send(8'hF0, 8'h3C, 3'(op), w);
    drain();
    check_val("t2_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_val("t2_result", {24'd0, got_q[i]}, {24'd0, t2_exp[i]});

    // 3: zero / all-ones flags
    got_q.delete();
    send(8'hAA, 8'h55, 3'd1, w);
    send(8'hAA, 8'h55, 3'd0, w);
    drain();
    check_val("t3_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check_val("t3_and", {24'd0, got_q[0]}, 32'h00);
      check_val("t3_or", {24'd0, got_q[1]}, 32'hFF);
    end

    // 4: back-pressure with three beats into a two-entry FIFO
    got_q.delete();
    out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h02, 3'd0, w);
        send(8'h0F, 8'hFF, 3'd1, w);
        send(8'h80, 8'h00, 3'd7, w);
        check_val("t4_third_held", {31'd0, (w > 0)}, 32'd1);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_val("t4_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      check_val("t4_r0", {24'd0, got_q[0]}, 32'h03);
      check_val("t4_r1", {24'd0, got_q[1]}, 32'h0F);
      check_val("t4_r2", {24'd0, got_q[2]}, 32'h7F);
    end

    // 5: 20-beat stream, one per cycle, no stalls
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)), w);
      check_val("t5_no_wait", w, 32'd0);
    end
    drain();
    check_val("t5_count", got_q.size(), 32'd20);

    // 6: reset with two entries queued discards them
    got_q.delete();
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd0, w);
    send(8'h33, 8'h44, 3'd0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("t6_flushed", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(new_a[0], 8'h00, 3'd6, w);
    send(new_a[1], 8'h00, 3'd6, w);
    drain();
    check_val("t6_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check_val("t6_r0", {24'd0, got_q[0]}, {24'd0, new_a[0]});
      check_val("t6_r1", {24'd0, got_q[1]}, {24'd0, new_a[1]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
